// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register with a one-entry skid buffer.
// Ready toward EXE depends only on registered state; bypass info is exported for both entries.
module exe_mem_skid_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,

  input  logic        exe_valid,
  output logic        exe_allowin,
  input  logic [4:0]  exe_rd,
  input  logic        exe_ref_we,
  input  logic        exe_dram_re,
  input  logic        exe_dram_we,
  input  logic        exe_res_from_dram,
  input  logic [31:0] exe_alu_result,
  input  logic [31:0] exe_dram_wdata,
  input  logic [31:0] exe_pc,

  output logic        mem_valid,
  input  logic        mem_allowin,
  output logic [4:0]  mem_rd,
  output logic        mem_ref_we,
  output logic        mem_dram_re,
  output logic        mem_dram_we,
  output logic        mem_res_from_dram,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_dram_wdata,
  output logic [31:0] mem_pc,

  output logic        fwd0_we,
  output logic [4:0]  fwd0_rd,
  output logic        fwd0_is_load,
  output logic [31:0] fwd0_data,

  output logic        fwd1_we,
  output logic [4:0]  fwd1_rd,
  output logic        fwd1_is_load,
  output logic [31:0] fwd1_data
);

  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic              ref_we;
    logic              dram_re;
    logic              dram_we;
    logic              res_from_dram;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] dram_wdata;
    logic [DATA_W-1:0] pc;
  } payload_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t   state_q;
  payload_t main_q;
  payload_t skid_q;
  payload_t in_p;

  logic main_valid;
  logic skid_valid;
  logic accept;
  logic drain;

  assign in_p = '{rd:            exe_rd,
                  ref_we:        exe_ref_we,
                  dram_re:       exe_dram_re,
                  dram_we:       exe_dram_we,
                  res_from_dram: exe_res_from_dram,
                  alu_result:    exe_alu_result,
                  dram_wdata:    exe_dram_wdata,
                  pc:            exe_pc};

  // Entry valid bits are a decode of the state register.
  assign main_valid  = (state_q != S_EMPTY);
  assign skid_valid  = (state_q == S_FULL);
  assign exe_allowin = !skid_valid;
  assign accept      = exe_valid & exe_allowin;
  assign drain       = main_valid & mem_allowin;

  // Occupancy FSM; the skid entry only ever refills main, which keeps FIFO order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_q <= S_ONE;
            main_q  <= in_p;
          end
        end
        S_ONE: begin
          if (accept && drain) begin
            main_q <= in_p;
          end else if (accept) begin
            state_q <= S_FULL;
            skid_q  <= in_p;
          end else if (drain) begin
            state_q <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (drain) begin
            state_q <= S_ONE;
            main_q  <= skid_q;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  assign mem_valid         = main_valid;
  assign mem_rd            = main_q.rd;
  assign mem_ref_we        = main_valid & main_q.ref_we;
  assign mem_dram_re       = main_valid & main_q.dram_re;
  assign mem_dram_we       = main_valid & main_q.dram_we;
  assign mem_res_from_dram = main_q.res_from_dram;
  assign mem_alu_result    = main_q.alu_result;
  assign mem_dram_wdata    = main_q.dram_wdata;
  assign mem_pc            = main_q.pc;

  // Bypass info is zero for any entry that is not holding an instruction.
  assign fwd0_we      = main_valid & main_q.ref_we;
  assign fwd0_rd      = main_valid ? main_q.rd : RD_W'(0);
  assign fwd0_is_load = main_valid & main_q.res_from_dram;
  assign fwd0_data    = main_valid ? main_q.alu_result : DATA_W'(0);

  assign fwd1_we      = skid_valid & skid_q.ref_we;
  assign fwd1_rd      = skid_valid ? skid_q.rd : RD_W'(0);
  assign fwd1_is_load = skid_valid & skid_q.res_from_dram;
  assign fwd1_data    = skid_valid ? skid_q.alu_result : DATA_W'(0);

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Self-checking bench for exe_mem_skid_reg: directed vector table, corner sequences
// and a randomized run against a two-deep FIFO reference model.
module tb_exe_mem_skid_reg;

  typedef struct packed {
    logic [4:0]  rd;
    logic        ref_we;
    logic        dram_re;
    logic        dram_we;
    logic        res_from_dram;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] pc;
  } pl_t;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] alu;
    logic        ma;
    logic        fl;
    logic        e_mv;
    logic [31:0] e_pc;
    logic [31:0] e_alu;
    logic        e_allow;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic exe_valid;
  logic mem_allowin;
  pl_t  in_p;

  logic        exe_allowin, mem_valid;
  logic [4:0]  mem_rd;
  logic        mem_ref_we, mem_dram_re, mem_dram_we, mem_res_from_dram;
  logic [31:0] mem_alu_result, mem_dram_wdata, mem_pc;
  logic        fwd0_we, fwd0_is_load, fwd1_we, fwd1_is_load;
  logic [4:0]  fwd0_rd, fwd1_rd;
  logic [31:0] fwd0_data, fwd1_data;

  int n_chk = 0;
  int n_fail = 0;
  pl_t q[$];

  always #5 clk = ~clk;

  exe_mem_skid_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .exe_valid(exe_valid), .exe_allowin(exe_allowin),
    .exe_rd(in_p.rd), .exe_ref_we(in_p.ref_we), .exe_dram_re(in_p.dram_re),
    .exe_dram_we(in_p.dram_we), .exe_res_from_dram(in_p.res_from_dram),
    .exe_alu_result(in_p.alu), .exe_dram_wdata(in_p.wdata), .exe_pc(in_p.pc),
    .mem_valid(mem_valid), .mem_allowin(mem_allowin),
    .mem_rd(mem_rd), .mem_ref_we(mem_ref_we), .mem_dram_re(mem_dram_re),
    .mem_dram_we(mem_dram_we), .mem_res_from_dram(mem_res_from_dram),
    .mem_alu_result(mem_alu_result), .mem_dram_wdata(mem_dram_wdata), .mem_pc(mem_pc),
    .fwd0_we(fwd0_we), .fwd0_rd(fwd0_rd), .fwd0_is_load(fwd0_is_load), .fwd0_data(fwd0_data),
    .fwd1_we(fwd1_we), .fwd1_rd(fwd1_rd), .fwd1_is_load(fwd1_is_load), .fwd1_data(fwd1_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic pl_t mk(input logic [31:0] pc, input logic [31:0] alu);
    pl_t p;
    p = '0;
    p.pc = pc;
    p.alu = alu;
    p.wdata = ~pc;
    p.rd = pc[6:2];
    p.ref_we = 1'b1;
    return p;
  endfunction

  // Compare every DUT output against the head/second entry of the reference FIFO.
  task automatic check_model();
    pl_t h;
    pl_t s;
    h = (q.size() > 0) ? q[0] : '0;
    s = (q.size() > 1) ? q[1] : '0;
    chk("mem_valid", 32'(mem_valid), 32'(q.size() > 0));
    chk("exe_allowin", 32'(exe_allowin), 32'(q.size() < 2));
    chk("mem_ref_we", 32'(mem_ref_we), 32'(h.ref_we));
    chk("mem_dram_re", 32'(mem_dram_re), 32'(h.dram_re));
    chk("mem_dram_we", 32'(mem_dram_we), 32'(h.dram_we));
    chk("fwd0_we", 32'(fwd0_we), 32'(h.ref_we));
    chk("fwd0_rd", 32'(fwd0_rd), 32'(h.rd));
    chk("fwd0_is_load", 32'(fwd0_is_load), 32'(h.res_from_dram));
    chk("fwd0_data", fwd0_data, h.alu);
    chk("fwd1_we", 32'(fwd1_we), 32'(s.ref_we));
    chk("fwd1_rd", 32'(fwd1_rd), 32'(s.rd));
    chk("fwd1_is_load", 32'(fwd1_is_load), 32'(s.res_from_dram));
    chk("fwd1_data", fwd1_data, s.alu);
    if (q.size() > 0) begin
      chk("mem_pc", mem_pc, h.pc);
      chk("mem_alu_result", mem_alu_result, h.alu);
      chk("mem_dram_wdata", mem_dram_wdata, h.wdata);
      chk("mem_rd", 32'(mem_rd), 32'(h.rd));
      chk("mem_res_from_dram", 32'(mem_res_from_dram), 32'(h.res_from_dram));
    end
  endtask

  // One clock: drive inputs, advance the FIFO model across the edge, check after it.
  task automatic step(input pl_t p, input logic v, input logic ma, input logic fl);
    bit acc;
    bit drn;
    in_p = p;
    exe_valid = v;
    mem_allowin = ma;
    flush = fl;
    acc = v && (q.size() < 2);
    drn = ma && (q.size() > 0);
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(p);
    end
    check_model();
  endtask

  vec_t tbl[11];

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    exe_valid = 1'b0;
    mem_allowin = 1'b0;
    in_p = '0;
    @(posedge clk);
    #1;
    chk("rst_exe_allowin", 32'(exe_allowin), 32'd1);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_pc", mem_pc, 32'd0);
    chk("rst_mem_alu", mem_alu_result, 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_fwd0_data", fwd0_data, 32'd0);
    chk("rst_fwd1_we", 32'(fwd1_we), 32'd0);
    rst = 1'b0;
    check_model();

    // Single pass, backpressure with refused third instruction, then flush from FULL.
    tbl[0]  = '{1'b1, 32'h1C000000, 32'h5,  1'b1, 1'b0, 1'b1, 32'h1C000000, 32'h5,  1'b1};
    tbl[1]  = '{1'b0, 32'h0,        32'h0,  1'b1, 1'b0, 1'b0, 32'h0,        32'h0,  1'b1};
    tbl[2]  = '{1'b1, 32'h100,      32'hA,  1'b0, 1'b0, 1'b1, 32'h100,      32'hA,  1'b1};
    tbl[3]  = '{1'b1, 32'h104,      32'hB,  1'b0, 1'b0, 1'b1, 32'h100,      32'hA,  1'b0};
    tbl[4]  = '{1'b1, 32'h108,      32'hC,  1'b0, 1'b0, 1'b1, 32'h100,      32'hA,  1'b0};
    tbl[5]  = '{1'b1, 32'h108,      32'hC,  1'b1, 1'b0, 1'b1, 32'h104,      32'hB,  1'b1};
    tbl[6]  = '{1'b0, 32'h0,        32'h0,  1'b1, 1'b0, 1'b0, 32'h0,        32'h0,  1'b1};
    tbl[7]  = '{1'b1, 32'h200,      32'h20, 1'b0, 1'b0, 1'b1, 32'h200,      32'h20, 1'b1};
    tbl[8]  = '{1'b1, 32'h204,      32'h24, 1'b0, 1'b0, 1'b1, 32'h200,      32'h20, 1'b0};
    tbl[9]  = '{1'b1, 32'h208,      32'h28, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,  1'b1};
    tbl[10] = '{1'b0, 32'h0,        32'h0,  1'b1, 1'b0, 1'b0, 32'h0,        32'h0,  1'b1};
    for (int i = 0; i < 11; i++) begin
      step(mk(tbl[i].pc, tbl[i].alu), tbl[i].v, tbl[i].ma, tbl[i].fl);
      chk($sformatf("vec%0d_mem_valid", i), 32'(mem_valid), 32'(tbl[i].e_mv));
      chk($sformatf("vec%0d_exe_allowin", i), 32'(exe_allowin), 32'(tbl[i].e_allow));
      if (tbl[i].e_mv) begin
        chk($sformatf("vec%0d_mem_pc", i), mem_pc, tbl[i].e_pc);
        chk($sformatf("vec%0d_mem_alu", i), mem_alu_result, tbl[i].e_alu);
      end else begin
        chk($sformatf("vec%0d_fwd0_we", i), 32'(fwd0_we), 32'd0);
        chk($sformatf("vec%0d_fwd1_we", i), 32'(fwd1_we), 32'd0);
      end
    end

    // Streaming: each pc appears at MEM one cycle after entry, state stays ONE.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] pc;
      pc = 32'h1C000000 + 32'(4 * i);
      step(mk(pc, pc ^ 32'h55), 1'b1, 1'b1, 1'b0);
      chk($sformatf("stream%0d_pc", i), mem_pc, pc);
      chk($sformatf("stream%0d_allowin", i), 32'(exe_allowin), 32'd1);
    end
    step('0, 1'b0, 1'b1, 1'b0);
    chk("stream_drained", 32'(mem_valid), 32'd0);

    // Forwarding: load to r7 in main, ALU op to r9 in skid.
    begin
      pl_t ld;
      pl_t alu;
      ld = mk(32'h300, 32'h1000);
      ld.rd = 5'd7; ld.dram_re = 1'b1; ld.res_from_dram = 1'b1;
      alu = mk(32'h304, 32'h1234);
      alu.rd = 5'd9;
      step(ld, 1'b1, 1'b0, 1'b0);
      step(alu, 1'b1, 1'b0, 1'b0);
      chk("fwd0_rd_7", 32'(fwd0_rd), 32'd7);
      chk("fwd0_is_load_1", 32'(fwd0_is_load), 32'd1);
      chk("fwd1_rd_9", 32'(fwd1_rd), 32'd9);
      chk("fwd1_we_1", 32'(fwd1_we), 32'd1);
      chk("fwd1_is_load_0", 32'(fwd1_is_load), 32'd0);
      chk("fwd1_data", fwd1_data, 32'h1234);
    end

    // Async reset between edges while FULL.
    exe_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_mem_valid", 32'(mem_valid), 32'd0);
    chk("arst_exe_allowin", 32'(exe_allowin), 32'd1);
    chk("arst_mem_pc", mem_pc, 32'd0);
    chk("arst_fwd1_we", 32'(fwd1_we), 32'd0);
    #2;
    rst = 1'b0;
    q.delete();
    step('0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_mem_valid", 32'(mem_valid), 32'd0);

    // Randomized traffic against the FIFO model.
    for (int i = 0; i < 400; i++) begin
      pl_t p;
      p.rd = 5'($urandom);
      p.ref_we = 1'($urandom);
      p.dram_re = 1'($urandom);
      p.dram_we = 1'($urandom);
      p.res_from_dram = 1'($urandom);
      p.alu = $urandom;
      p.wdata = $urandom;
      p.pc = $urandom;
      step(p, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_mem_skid_reg.md
EXE_MEM_SKID_REG -- requirements
Module: exe_mem_skid_reg

Interface
REQ-001 SHALL have clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have exe_valid, input, 1 bit: EXE offers an instruction this cycle.
REQ-004 SHALL have exe_allowin, output, 1 bit: this block can accept from EXE.
REQ-005 SHALL have exe_rd (5 bits), exe_ref_we (1), exe_dram_re (1), exe_dram_we (1), exe_res_from_dram (1), exe_alu_result (32), exe_dram_wdata (32) and exe_pc (32), all inputs: the instruction payload.
REQ-006 SHALL have mem_valid, output, 1 bit: an instruction is presented to MEM.
REQ-007 SHALL have mem_allowin, input, 1 bit: MEM accepts this cycle.
REQ-008 SHALL have mem_rd, mem_ref_we, mem_dram_re, mem_dram_we, mem_res_from_dram, mem_alu_result, mem_dram_wdata and mem_pc, all outputs, each the same width as its exe_ counterpart.
REQ-009 SHALL have flush, input, 1 bit: discard all held and incoming instructions.
REQ-010 SHALL have fwd0_we (1), fwd0_rd (5), fwd0_is_load (1) and fwd0_data (32), outputs: bypass info for the main entry.
REQ-011 SHALL have fwd1_we, fwd1_rd, fwd1_is_load and fwd1_data, outputs of the same widths: bypass info for the skid entry.

Function
REQ-012 SHALL hold two entries, main and skid, each storing the full payload plus a valid bit.
REQ-013 SHALL define accept = exe_valid & exe_allowin and drain = mem_valid & mem_allowin.
REQ-014 SHALL drive exe_allowin = !skid_valid, decoded from registered state only, with no combinational path from mem_allowin.
REQ-015 SHALL drive mem_valid = main_valid, with the mem_* payload taken from the main entry.
REQ-016 SHALL run a three-state machine: EMPTY (no entry valid), ONE (main valid only) and FULL (main and skid valid).
REQ-017 SHALL move EMPTY to ONE on accept, loading main from the inputs.
REQ-018 SHALL handle ONE as follows:
- accept & drain: stay ONE, main loads the inputs.
- accept & !drain: go FULL, skid loads the inputs.
- !accept & drain: go EMPTY.
- neither: hold.
REQ-019 SHALL move FULL to ONE on drain, main loading from skid; with no drain it holds, and accept is impossible in FULL.
REQ-020 SHALL preserve FIFO order: the skid entry never reaches MEM before the main entry.
REQ-021 SHALL present an accepted instruction at the mem_* outputs one cycle after acceptance when main is empty or draining that cycle.
REQ-022 SHALL, on flush, clear both valid bits at the next edge and go EMPTY.
- Any accept in that cycle is discarded.
- flush has priority over every other event.
REQ-023 SHALL gate mem_ref_we, mem_dram_we and mem_dram_re with main_valid.
REQ-024 SHALL drive fwd0_we = main_valid & main ref_we and fwd1_we = skid_valid & skid ref_we.
REQ-025 SHALL drive fwdN_rd, fwdN_data (the alu_result) and fwdN_is_load (the res_from_dram) from the respective entry, all forced to 0 when that entry is invalid.
REQ-026 SHALL leave payload registers unchanged when not loaded, with no zeroing on bubble.

Reset
REQ-027 SHALL, while rst=1, asynchronously clear both valid bits and state to EMPTY and zero all payload registers.
REQ-028 SHALL output during reset: exe_allowin=1, mem_valid=0, all mem_* = 0 and all fwd* = 0.
REQ-029 SHALL discard any in-flight instruction when reset is asserted mid-operation, with no partial update on the first edge after release.

Verification
REQ-030 SHALL cover single pass: EMPTY, exe_valid=1, pc=0x1C000000, alu_result=0x5, mem_allowin=1 -> next cycle mem_valid=1, mem_pc=0x1C000000, mem_alu_result=0x5.
REQ-031 SHALL cover backpressure: mem_allowin=0, send A (pc 0x100) then B (pc 0x104) -> state FULL, exe_allowin=0, mem_pc=0x100. Then mem_allowin=1 -> mem_pc=0x100, then 0x104, with C not accepted while FULL.
REQ-032 SHALL cover streaming: exe_valid=1 and mem_allowin=1 for 8 cycles with pc incrementing by 4 -> state stays ONE and every pc reaches MEM exactly once, in order, one cycle after entry.
REQ-033 SHALL cover flush: state FULL, flush=1 with exe_valid=1 -> next cycle mem_valid=0, exe_allowin=1, fwd0_we=0, fwd1_we=0.
REQ-034 SHALL cover forwarding: load to rd=7 held in main and ALU op writing rd=9 in skid -> fwd0_rd=7, fwd0_is_load=1, fwd1_rd=9, fwd1_we=1, fwd1_is_load=0.
REQ-035 SHALL cover async reset: rst pulsed between clock edges while FULL -> mem_valid=0 and exe_allowin=1 immediately, before the next edge.
